// File: rtl/ram8_16.sv
// Eight-word register-file RAM with a registered, write-first read port and a
// self-timed clear-all sequence that zeroes one word per cycle.
module ram8_16 #(
   parameter int unsigned WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] in,
   input  logic             load,
   input  logic [2:0]       addr,
   input  logic [2:0]       raddr,
   input  logic             clr,
   output logic [WIDTH-1:0] out,
   output logic             busy
);

   typedef enum logic [0:0] {StIdle, StClear} state_e;

   state_e           state_q, state_d;
   logic [2:0]       cnt_q, cnt_d;
   logic [WIDTH-1:0] mem_q [8];
   logic [WIDTH-1:0] out_q, out_d;

   logic             we;
   logic [2:0]       waddr;
   logic [WIDTH-1:0] wdata;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      we      = 1'b0;
      waddr   = addr;
      wdata   = in;
      unique case (state_q)
         StIdle: begin
            if (clr) begin
               // clr beats a simultaneous load; the write is dropped.
               state_d = StClear;
               cnt_d   = 3'd0;
            end else if (load) begin
               we = 1'b1;
            end
         end
         StClear: begin
            we    = 1'b1;
            waddr = cnt_q;
            wdata = '0;
            cnt_d = cnt_q + 3'd1;
            if (cnt_q == 3'd7) begin
               state_d = StIdle;
            end
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // Write-first: a word committed this edge to the read address is forwarded.
   always_comb begin
      out_d = mem_q[raddr];
      if (we && (waddr == raddr)) begin
         out_d = wdata;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= StIdle;
         cnt_q   <= 3'd0;
         out_q   <= '0;
         for (int i = 0; i < 8; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         out_q   <= out_d;
         if (we) begin
            mem_q[waddr] <= wdata;
         end
      end
   end

   assign out  = out_q;
   assign busy = (state_q == StClear);

endmodule
